// File: rtl/param_dff_pkg.sv
// Shared constants for the param_dff register bank.
package param_dff_pkg;

  localparam int unsigned DEFAULT_WIDTH = 9;

endpackage : param_dff_pkg

// File: rtl/d_ff.sv
// Single-bit rising-edge flop with asynchronous active-low reset to 0.
module d_ff (
  output logic q,
  input  logic d,
  input  logic reset,
  input  logic clk
);

  logic state_d;
  logic state_q;

  always_comb begin
    state_d = d;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule : d_ff

// File: rtl/param_dff.sv
// WIDTH-bit pipeline register built from one d_ff per bit; async active-low reset to RESET_VALUE.
module param_dff
  import param_dff_pkg::*;
#(
  parameter int unsigned       WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             reset,
  input  logic             clk
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (RESET_VALUE[i]) begin : g_set
      // A reset-to-1 bit stores the inverted value so the plain reset-to-0 flop can be reused.
      logic d_n;
      logic q_n;

      assign d_n = ~d[i];

      d_ff u_ff (
        .q     (q_n),
        .d     (d_n),
        .reset (reset),
        .clk   (clk)
      );

      assign q[i] = ~q_n;
    end else begin : g_clr
      d_ff u_ff (
        .q     (q[i]),
        .d     (d[i]),
        .reset (reset),
        .clk   (clk)
      );
    end
  end

endmodule : param_dff

// File: tb/tb_param_dff.sv
// Scoreboard bench: several param_dff widths share one clock/reset; a monitor compares q after every edge.
module tb_param_dff;

  localparam int TW = 24;
  // Concatenation order {w9, w4, w2, w1, w5, w3}; only the 4-bit instance has a non-zero reset value.
  localparam logic [TW-1:0] RV_ALL = {9'd0, 4'b1010, 2'd0, 1'b0, 5'd0, 3'd0};

  typedef struct {
    logic [TW-1:0] value;
    string         tag;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [TW-1:0] d_all;
  logic [TW-1:0] q_all;

  logic [8:0] d9, q9;
  logic [3:0] d4, q4;
  logic [1:0] d2, q2;
  logic       d1, q1;
  logic [4:0] d5, q5;
  logic [2:0] d3, q3;

  assign {d9, d4, d2, d1, d5, d3} = d_all;
  assign q_all = {q9, q4, q2, q1, q5, q3};

  param_dff #(.WIDTH(3)) u_w3 (.d(d3), .q(q3), .reset(rst_n), .clk(clk));
  param_dff #(.WIDTH(5)) u_w5 (.d(d5), .q(q5), .reset(rst_n), .clk(clk));
  param_dff #(.WIDTH(1)) u_w1 (.d(d1), .q(q1), .reset(rst_n), .clk(clk));
  param_dff #(.WIDTH(2)) u_w2 (.d(d2), .q(q2), .reset(rst_n), .clk(clk));
  param_dff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_w4 (.d(d4), .q(q4), .reset(rst_n), .clk(clk));
  param_dff u_w9 (.d(d9), .q(q9), .reset(rst_n), .clk(clk));

  exp_t          sb[$];
  int            n_vec;
  int            n_err;
  logic [TW-1:0] prev_exp;
  bit            have_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [TW-1:0] pack(input logic [8:0] a9, input logic [3:0] a4,
                                          input logic [1:0] a2, input logic a1,
                                          input logic [4:0] a5, input logic [2:0] a3);
    return {a9, a4, a2, a1, a5, a3};
  endfunction

  // One vector per clock: drive at the falling edge, predict what the next rising edge must show.
  task automatic step(input logic [TW-1:0] dv, input logic rv, input string tag);
    logic          was_rst;
    logic [TW-1:0] e;
    @(negedge clk);
    if (have_prev) check({tag, "_mid_hold"}, q_all, prev_exp);
    was_rst = ~rst_n;
    rst_n   = rv;
    d_all   = dv;
    e       = rv ? dv : RV_ALL;
    sb.push_back('{value: e, tag: tag});
    #1;
    if (!rv)          check({tag, "_async_reset"}, q_all, RV_ALL);
    else if (was_rst) check({tag, "_release_hold"}, q_all, RV_ALL);
    prev_exp  = e;
    have_prev = 1'b1;
  endtask

  initial begin : monitor
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        item = sb.pop_front();
        check({item.tag, "_edge"}, q_all, item.value);
      end
    end
  end

  initial begin : stimulus
    n_vec     = 0;
    n_err     = 0;
    have_prev = 1'b0;
    prev_exp  = '0;
    rst_n     = 1'b1;
    d_all     = '0;

    step(pack(9'h1a5, 4'b0101, 2'b00, 1'b0, 5'b00000, 3'b101), 1'b1, "init");
    step(pack(9'h1a5, 4'b0101, 2'b00, 1'b0, 5'b00000, 3'b101), 1'b0, "rst_a");
    step(pack(9'h1a5, 4'b0101, 2'b00, 1'b0, 5'b00000, 3'b101), 1'b0, "rst_b");
    step(pack(9'h0f0, 4'b0011, 2'b01, 1'b1, 5'b00001, 3'b001), 1'b1, "rel");
    step(pack(9'h00f, 4'b0110, 2'b10, 1'b1, 5'b00010, 3'b001), 1'b1, "hold1");
    step(pack(9'h111, 4'b1001, 2'b01, 1'b0, 5'b00100, 3'b001), 1'b1, "hold2");
    step(pack(9'h0aa, 4'b1111, 2'b10, 1'b1, 5'b01000, 3'b001), 1'b1, "hold3");
    step(pack(9'h155, 4'b0000, 2'b11, 1'b1, 5'b10000, 3'b001), 1'b1, "hold4");
    step(pack(9'h1ff, 4'b0001, 2'b11, 1'b1, 5'b11111, 3'b010), 1'b1, "chg");
    step(pack(9'h1ff, 4'b0001, 2'b11, 1'b1, 5'b11111, 3'b010), 1'b0, "rst_mid");
    step(pack(9'h0c3, 4'b0110, 2'b01, 1'b0, 5'b10101, 3'b110), 1'b1, "rel2");

    for (int i = 0; i < 300; i++) begin
      logic [TW-1:0] dv;
      logic          rv;
      dv = TW'($urandom());
      rv = ($urandom_range(0, 15) != 0);
      step(dv, rv, "rand");
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected values never checked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_param_dff
